ascon_spi_target: RTL
=====================

// Module: ascon_spi_target
// PURPOSE
//  SPI mode-0 target. Host-side counterpart of the Ascon core: writes key/nonce/data
//  operand registers, shifts words into the permutation state, reads state words
//  back, and issues the operation start command. Drives reg*_128b,
//  state_shift_* and operation_mode/ready. Receives S_0..S_4_reg.
// PARAMETERS
//  SYNC_STAGES  2  flip-flop synchronizer depth on sclk, cs_n and mosi (>=2)
// PORTS
//  clk              in   1    system clock; must be >= 4x the sclk frequency
//  rst_n            in   1    asynchronous, active-low reset
//  sclk             in   1    SPI clock (asynchronous)
//  cs_n             in   1    SPI chip select, active low (asynchronous)
//  mosi             in   1    SPI data in (asynchronous)
//  miso             out  1    SPI data out, MSB first
//  S_0_reg..S_4_reg in   64   permutation state words (read source)
//  reg0_128b        out  128  key operand
//  reg1_128b        out  128  text operand
//  reg2_128b        out  128  associated-data operand
//  operation_mode   out  3    latched mode (0 idle,1 enc,2 dec,3 hash,4 xof,5 cxof)
//  operation_ready  out  1    one-clk start pulse
//  state_shift_en   out  1    one-clk pulse per state bit written
//  state_shift_sel  out  3    target state word 0..4
//  state_shift_lsb  out  1    bit shifted into the LSB of the selected word
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; bit counter 0; shadow registers 0.
//  - Inputs pass through SYNC_STAGES flip-flops. Edges come from the synchronized sclk.
//    Rise: sample mosi. Fall: update miso. Latency is SYNC_STAGES+1 clk from a pin edge.
//  - Transaction framing:
//    - cs_n falling (synced): enter CMD with bit_cnt=0.
//    - cs_n high, in any state: return to IDLE next clk; miso=0.
//  - Command byte, MSB first: [7:5] opcode, [4:3] ignored, [2:0] sel.
//    - 3'b001 WR_REG    sel 0..2; 128 data bits.
//    - 3'b010 WR_STATE  sel 0..4; 64 data bits.
//    - 3'b011 RD_STATE  sel 0..4; 64 data bits.
//    - 3'b100 START     sel = mode; no data.
//    - Any other opcode, or sel out of range: go to IGNORE (no side effects, miso=0)
//      until cs_n rises.
//  - FSM states: IDLE -> CMD -> (DATA | IGNORE) -> IDLE.
//    - CMD -> DATA or IGNORE on the 8th sampled rise.
//    - DATA -> IGNORE when bit_cnt reaches its length (128 or 64). Extra bits are discarded.
//  - bit_cnt is 7 bits. It resets to 0 on entering CMD and again on entering DATA.
//    It never wraps; it saturates in IGNORE.
//  - WR_REG:
//    - Each rise shifts mosi into a 128b shadow register.
//    - On the 128th rise, the shadow is copied to reg<sel>_128b in the same clk.
//    - If cs_n rises early, the target register is unchanged.
//  - WR_STATE:
//    - Each rise produces a one-clk pulse: state_shift_en=1, state_shift_sel=sel,
//      state_shift_lsb=the sampled bit.
//    - Contract: the core performs S_sel <= {S_sel[62:0], lsb}.
//    - Aborting early leaves the bits already shifted in place; this is not undone.
//    - state_shift_sel holds its last value between pulses.
//  - RD_STATE:
//    - On the 8th command rise, S_<sel>_reg is captured into a 64b shadow.
//    - miso = shadow[63] from the following fall.
//    - Each later fall shifts the shadow left and fills with 0.
//    - After 64 bits, miso=0.
//  - START:
//    - On the 8th rise, operation_mode <= sel (0..5 only).
//    - operation_ready pulses high exactly one clk later.
//    - operation_mode holds until the next START.
//  - In CMD, miso=0.
//  - An sclk edge coincident with cs_n rising (same synced clk): the cs_n rise wins and
//    the edge is ignored.
//  - rst_n low mid-transaction: immediate return to reset values.
//    - Operand registers clear.
//    - The bench must reassert cs_n to start a new transaction.
// TESTING
//  - WR_REG sel=0, data 128'h000102..0F: reg0_128b equals it after the 128th bit.
//    reg1 and reg2 stay 0.
//  - WR_REG sel=1, abort after 100 bits, then a full write of all-ones:
//    reg1 is still 0 after the abort and all-ones at the end.
//  - WR_STATE sel=3, 64'h8000_0000_0000_0001: exactly 64 state_shift_en pulses.
//    state_shift_sel=3; the lsb sequence is 1, 62x0, 1.
//  - RD_STATE sel=4 with S_4_reg=64'hDEADBEEF_01234567: miso returns the same 64 bits
//    MSB first, then 0. A change to S_4 mid-read does not alter the output.
//  - START sel=5: operation_mode=5 and a single-clk operation_ready.
//    Then opcode 3'b111 and START sel=6: no pulse, mode stays 5.
//  - rst_n pulsed during a WR_REG at bit 50: all outputs 0.
//    The next full transaction completes correctly.

Source files
------------

// File: rtl/ascon_spi_target.sv
// ascon_spi_target: SPI mode-0 target that loads Ascon operands, shifts words
// into the permutation state, reads state words back and issues start commands.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no transaction; wait for a synchronized cs_n falling edge
// ST_CMD    | shifting in the 8-bit command byte, miso held at 0
// ST_DATA   | data phase of WR_REG / WR_STATE / RD_STATE
// ST_IGNORE | payload done, bad command or START; discard bits until cs_n rises
module ascon_spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sclk,
  input  logic         cs_n,
  input  logic         mosi,
  output logic         miso,
  input  logic [63:0]  S_0_reg,
  input  logic [63:0]  S_1_reg,
  input  logic [63:0]  S_2_reg,
  input  logic [63:0]  S_3_reg,
  input  logic [63:0]  S_4_reg,
  output logic [127:0] reg0_128b,
  output logic [127:0] reg1_128b,
  output logic [127:0] reg2_128b,
  output logic [2:0]   operation_mode,
  output logic         operation_ready,
  output logic         state_shift_en,
  output logic [2:0]   state_shift_sel,
  output logic         state_shift_lsb
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_DATA   = 2'd2,
    ST_IGNORE = 2'd3
  } state_t;

  localparam logic [2:0] OP_WR_REG   = 3'b001;
  localparam logic [2:0] OP_WR_STATE = 3'b010;
  localparam logic [2:0] OP_RD_STATE = 3'b011;
  localparam logic [2:0] OP_START    = 3'b100;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall;

  state_t       state_q;
  logic [6:0]   bit_cnt_q;
  logic [6:0]   cmd_q;
  logic [2:0]   op_q;
  logic [2:0]   sel_q;
  logic [127:0] wr_sh_q;
  logic [63:0]  rd_sh_q;
  logic [127:0] reg0_q, reg1_q, reg2_q;
  logic [2:0]   mode_q;
  logic         start_pend_q;
  logic         ready_q;
  logic         shift_en_q;
  logic [2:0]   shift_sel_q;
  logic         shift_lsb_q;
  logic         miso_q;

  logic [7:0]   cmd_d;
  logic [2:0]   opc_d, sel_d;
  logic [1:0]   cmd_unused;
  logic [63:0]  s_sel_d;
  logic [127:0] wr_sh_d;

  // Synchronize the asynchronous SPI pins and keep one history bit for edge detection.
  // Reset to 0 so a cs_n held low through reset cannot fake a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign cmd_d      = {cmd_q, mosi_s};
  assign opc_d      = cmd_d[7:5];
  assign sel_d      = cmd_d[2:0];
  assign cmd_unused = cmd_d[4:3];
  assign wr_sh_d    = {wr_sh_q[126:0], mosi_s};

  // Read-source mux for RD_STATE capture, indexed by the command byte being completed.
  always_comb begin
    s_sel_d = '0;
    case (sel_d)
      3'd0:    s_sel_d = S_0_reg;
      3'd1:    s_sel_d = S_1_reg;
      3'd2:    s_sel_d = S_2_reg;
      3'd3:    s_sel_d = S_3_reg;
      3'd4:    s_sel_d = S_4_reg;
      default: s_sel_d = '0;
    endcase
  end

  // Transaction FSM with all outputs registered; cs_n high overrides any sclk edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      cmd_q        <= '0;
      op_q         <= '0;
      sel_q        <= '0;
      wr_sh_q      <= '0;
      rd_sh_q      <= '0;
      reg0_q       <= '0;
      reg1_q       <= '0;
      reg2_q       <= '0;
      mode_q       <= '0;
      start_pend_q <= 1'b0;
      ready_q      <= 1'b0;
      shift_en_q   <= 1'b0;
      shift_sel_q  <= '0;
      shift_lsb_q  <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      ready_q      <= start_pend_q;
      start_pend_q <= 1'b0;
      shift_en_q   <= 1'b0;
      if (cs_s) begin
        state_q <= ST_IDLE;
        miso_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            miso_q <= 1'b0;
            if (cs_fall) begin
              state_q   <= ST_CMD;
              bit_cnt_q <= '0;
            end
          end
          ST_CMD: begin
            miso_q <= 1'b0;
            if (sclk_rise) begin
              cmd_q <= cmd_d[6:0];
              if (bit_cnt_q == 7'd7) begin
                bit_cnt_q <= '0;
                op_q      <= opc_d;
                sel_q     <= sel_d;
                state_q   <= ST_IGNORE;
                case (opc_d)
                  OP_WR_REG: begin
                    if (sel_d <= 3'd2) state_q <= ST_DATA;
                  end
                  OP_WR_STATE: begin
                    if (sel_d <= 3'd4) state_q <= ST_DATA;
                  end
                  OP_RD_STATE: begin
                    if (sel_d <= 3'd4) begin
                      state_q <= ST_DATA;
                      rd_sh_q <= s_sel_d;
                    end
                  end
                  OP_START: begin
                    if (sel_d <= 3'd5) begin
                      mode_q       <= sel_d;
                      start_pend_q <= 1'b1;
                    end
                  end
                  default: ;
                endcase
              end else begin
                bit_cnt_q <= bit_cnt_q + 7'd1;
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              case (op_q)
                OP_WR_REG: begin
                  wr_sh_q <= wr_sh_d;
                  if (bit_cnt_q == 7'd127) begin
                    state_q <= ST_IGNORE;
                    case (sel_q)
                      3'd0:    reg0_q <= wr_sh_d;
                      3'd1:    reg1_q <= wr_sh_d;
                      3'd2:    reg2_q <= wr_sh_d;
                      default: ;
                    endcase
                  end else begin
                    bit_cnt_q <= bit_cnt_q + 7'd1;
                  end
                end
                OP_WR_STATE: begin
                  shift_en_q  <= 1'b1;
                  shift_sel_q <= sel_q;
                  shift_lsb_q <= mosi_s;
                  bit_cnt_q   <= bit_cnt_q + 7'd1;
                  if (bit_cnt_q == 7'd63) state_q <= ST_IGNORE;
                end
                default: begin
                  bit_cnt_q <= bit_cnt_q + 7'd1;
                  if (bit_cnt_q == 7'd63) begin
                    state_q <= ST_IGNORE;
                    miso_q  <= 1'b0;
                  end
                end
              endcase
            end else if (sclk_fall && op_q == OP_RD_STATE) begin
              miso_q  <= rd_sh_q[63];
              rd_sh_q <= {rd_sh_q[62:0], 1'b0};
            end
          end
          ST_IGNORE: begin
            miso_q <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            miso_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign miso            = miso_q;
  assign reg0_128b       = reg0_q;
  assign reg1_128b       = reg1_q;
  assign reg2_128b       = reg2_q;
  assign operation_mode  = mode_q;
  assign operation_ready = ready_q;
  assign state_shift_en  = shift_en_q;
  assign state_shift_sel = shift_sel_q;
  assign state_shift_lsb = shift_lsb_q;

endmodule
